// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/result bundle between operand registers and the multiplier
interface seq_multiplier_if #(
  parameter int N = 4
);
  logic           loaded;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           done;
  logic           busy;
  logic [2*N-1:0] result;

  modport master (
    output loaded, a, b,
    input  done, busy, result
  );

  modport slave (
    input  loaded, a, b,
    output done, busy, result
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - unsigned shift-add multiplier, fixed N-cycle iteration
module seq_multiplier #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_multiplier_if.slave  bus
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] result_q, result_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.loaded) begin
          mcand_d  = {{N{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Final iteration publishes the sum including this edge's partial product.
        if (cnt_q == LAST) begin
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flags are registered, so derive them from where the FSM is heading.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - bench for seq_multiplier with cycle model and directed vectors
module tb_seq_multiplier;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   done_count;

  seq_multiplier_if #(.N(N)) bus ();

  seq_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: a start is a cycle where the idle unit sees loaded; the product is a*b,
  // reported N edges later, and the unit is busy for N+1 cycles.
  int             m_phase;
  logic [2*N-1:0] m_prod;
  logic [2*N-1:0] m_result;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase  = -1;
      m_result = '0;
    end else if (m_phase < 0) begin
      if (bus.loaded) begin
        m_phase = 0;
        m_prod  = {{N{1'b0}}, bus.a} * {{N{1'b0}}, bus.b};
      end
    end else begin
      m_phase++;
      if (m_phase == N) m_result = m_prod;
      if (m_phase > N) m_phase = -1;
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    chk("model_busy", 16'(bus.busy), 16'(m_phase >= 0));
    chk("model_done", 16'(bus.done), 16'(m_phase == N));
    chk("model_result", 16'(bus.result), 16'(m_result));
    if (bus.done) done_count++;
  end

  task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input bit chg, input bit lit);
    int lat;
    int busy_n;
    int d0;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.loaded = 1'b1;
    d0 = done_count;
    @(posedge clk);
    @(negedge clk);
    bus.loaded = 1'b0;
    if (chg) begin
      bus.a = 4'h1;
      bus.b = 4'h1;
    end
    lat = 0;
    busy_n = 0;
    while (!bus.done && lat < 20) begin
      lat++;
      if (bus.busy) busy_n++;
      @(negedge clk);
    end
    if (bus.busy) busy_n++;
    chk("latency", 16'(lat), 16'(N));
    chk("result", 16'(bus.result), 16'(exp));
    if (lit) chk("busy_len", 16'(busy_n), 16'(N + 1));
    @(negedge clk);
    chk("done_fall", 16'(bus.done), 16'd0);
    chk("busy_fall", 16'(bus.busy), 16'd0);
    chk("one_done", 16'(done_count - d0), 16'd1);
  endtask

  initial begin
    int t1;
    int t2;
    int d0;
    int lat;
    total = 0;
    bad = 0;
    cyc = 0;
    done_count = 0;
    rst = 1'b0;
    bus.loaded = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_result", 16'(bus.result), 16'd0);
    rst = 1'b1;
    @(negedge clk);

    do_mul(4'hF, 4'hF, 8'hE1, 1'b0, 1'b1);
    do_mul(4'h0, 4'hB, 8'h00, 1'b0, 1'b1);
    do_mul(4'h3, 4'h5, 8'h0F, 1'b0, 1'b1);
    do_mul(4'h7, 4'h6, 8'h2A, 1'b1, 1'b1);

    // loaded held through done: a second multiply follows immediately
    @(negedge clk);
    bus.a = 4'hF;
    bus.b = 4'h1;
    bus.loaded = 1'b1;
    d0 = done_count;
    lat = 0;
    while (!bus.done && lat < 20) begin lat++; @(negedge clk); end
    t1 = cyc;
    chk("b2b_first", 16'(bus.result), 16'h0F);
    bus.a = 4'h2;
    bus.b = 4'h9;
    @(negedge clk);
    lat = 0;
    while (!bus.done && lat < 20) begin lat++; @(negedge clk); end
    t2 = cyc;
    bus.loaded = 1'b0;
    chk("b2b_result", 16'(bus.result), 16'h12);
    chk("b2b_spacing", 16'(t2 - t1), 16'd6);
    repeat (10) @(negedge clk);
    chk("b2b_count", 16'(done_count - d0), 16'd2);

    // reset in the middle of RUN
    @(negedge clk);
    bus.a = 4'hF;
    bus.b = 4'hF;
    bus.loaded = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.loaded = 1'b0;
    repeat (2) @(negedge clk);
    d0 = done_count;
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 16'(bus.busy), 16'd0);
    chk("midrst_done", 16'(bus.done), 16'd0);
    chk("midrst_result", 16'(bus.result), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_nodone", 16'(done_count - d0), 16'd0);
    do_mul(4'h5, 4'h5, 8'h19, 1'b0, 1'b1);

    for (int i = 0; i < 256; i++) begin
      logic [N-1:0] x;
      logic [N-1:0] y;
      x = 4'(i >> 4);
      y = 4'(i);
      do_mul(x, y, 8'(x * y), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
